// File: rtl/dino_pkg.sv
// Shared types and helpers for the VGA/CPU mailbox: FSM states and the
// replicated 3-bit status word format read by the CPU from r20/r22.
package dino_pkg;

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        READY      = 1'b1
    } mailbox_state_t;

    localparam int STATUS_PAD_W = 29;

    // The CPU polls a single bit, but the word carries three copies so any
    // of the low bits can be tested.
    function automatic logic [31:0] rep3_status(input logic b);
        return {{STATUS_PAD_W{1'b0}}, {3{b}}};
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Pushbutton conditioning: 2-flop synchronizer, stability counter and a
// registered one-cycle pulse on the debounced rising edge.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic button_raw,
    output logic btn_db,
    output logic button_pressed
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             btn_db_reg;
    logic             btn_db_d_reg;
    logic             pressed_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_reg    <= 1'b0;
            sync2_reg    <= 1'b0;
            btn_db_reg   <= 1'b0;
            btn_db_d_reg <= 1'b0;
            pressed_reg  <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            sync1_reg    <= button_raw;
            sync2_reg    <= sync1_reg;
            btn_db_d_reg <= btn_db_reg;
            pressed_reg  <= btn_db_reg & ~btn_db_d_reg;
            // Any sample that agrees with the debounced level restarts the count.
            if (sync2_reg == btn_db_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                btn_db_reg <= sync2_reg;
                cnt_reg    <= '0;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign btn_db         = btn_db_reg;
    assign button_pressed = pressed_reg;

endmodule

// File: rtl/frame_coord_mailbox.sv
// Frame handshake between the VGA controller and the game CPU: one ready per
// frame, atomic capture of CPU coordinates into display shadows, overrun count.
module frame_coord_mailbox
    import dino_pkg::*;
#(
    parameter int COORD_W         = 32,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int OVR_W           = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               button_raw,
    input  logic               frame_end,
    input  logic               cpu_commit,
    input  logic [COORD_W-1:0] cpu_x,
    input  logic [COORD_W-1:0] cpu_y,
    input  logic [COORD_W-1:0] cpu_obs_x,
    input  logic [COORD_W-1:0] cpu_obs_y,
    output logic [COORD_W-1:0] disp_x,
    output logic [COORD_W-1:0] disp_y,
    output logic [COORD_W-1:0] disp_obs_x,
    output logic [COORD_W-1:0] disp_obs_y,
    output logic [31:0]        screen_status,
    output logic [31:0]        button_status,
    output logic               button_pressed,
    output logic [OVR_W-1:0]   overrun_count
);

    mailbox_state_t   state_reg;
    mailbox_state_t   state_next;
    logic             capture;
    logic             overrun_inc;
    logic [OVR_W-1:0] overrun_reg;
    logic             btn_db;

    logic [3:0][COORD_W-1:0] cpu_coord;
    logic [3:0][COORD_W-1:0] disp_coord;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_debounce (
        .clk           (clk),
        .reset         (reset),
        .button_raw    (button_raw),
        .btn_db        (btn_db),
        .button_pressed(button_pressed)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= WAIT_FRAME;
            overrun_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (overrun_inc && (overrun_reg != '1)) begin
                overrun_reg <= overrun_reg + OVR_W'(1);
            end
        end
    end

    // A commit coinciding with frame_end is consumed, yet the new frame
    // still owes the CPU a ready, so the FSM stays in READY.
    always_comb begin
        state_next  = state_reg;
        capture     = 1'b0;
        overrun_inc = 1'b0;
        case (state_reg)
            WAIT_FRAME: begin
                if (frame_end) state_next = READY;
            end
            READY: begin
                if (cpu_commit) begin
                    capture = 1'b1;
                    if (!frame_end) state_next = WAIT_FRAME;
                end else if (frame_end) begin
                    overrun_inc = 1'b1;
                end
            end
            default: state_next = WAIT_FRAME;
        endcase
    end

    assign cpu_coord = {cpu_obs_y, cpu_obs_x, cpu_y, cpu_x};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_shadow
            logic [COORD_W-1:0] shadow_reg;
            always_ff @(posedge clk) begin
                if (!reset) begin
                    shadow_reg <= '0;
                end else if (capture) begin
                    shadow_reg <= cpu_coord[gi];
                end
            end
            assign disp_coord[gi] = shadow_reg;
        end
    endgenerate

    assign disp_x        = disp_coord[0];
    assign disp_y        = disp_coord[1];
    assign disp_obs_x    = disp_coord[2];
    assign disp_obs_y    = disp_coord[3];
    assign screen_status = rep3_status(state_reg == READY);
    assign button_status = rep3_status(btn_db);
    assign overrun_count = overrun_reg;

endmodule

// File: tb/tb_frame_coord_mailbox.sv
// Directed plus randomized checks of frame_coord_mailbox against a
// cycle-level behavioural model of the handshake and debounce rules.
module tb_frame_coord_mailbox;

    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        button_raw;
    logic        frame_end;
    logic        cpu_commit;
    logic [31:0] cpu_x, cpu_y, cpu_obs_x, cpu_obs_y;
    logic [31:0] disp_x, disp_y, disp_obs_x, disp_obs_y;
    logic [31:0] screen_status;
    logic [31:0] button_status;
    logic        button_pressed;
    logic [15:0] overrun_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic        m_ready;
    logic [31:0] m_disp [4];
    int          m_ovr;
    logic        m_db;
    int          m_run;
    logic        m_rose;
    logic        m_pressed;
    logic        samp [$];

    always #5 clk = ~clk;

    frame_coord_mailbox #(
        .COORD_W        (32),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (3),
        .OVR_W          (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .button_raw    (button_raw),
        .frame_end     (frame_end),
        .cpu_commit    (cpu_commit),
        .cpu_x         (cpu_x),
        .cpu_y         (cpu_y),
        .cpu_obs_x     (cpu_obs_x),
        .cpu_obs_y     (cpu_obs_y),
        .disp_x        (disp_x),
        .disp_y        (disp_y),
        .disp_obs_x    (disp_obs_x),
        .disp_obs_y    (disp_obs_y),
        .screen_status (screen_status),
        .button_status (button_status),
        .button_pressed(button_pressed),
        .overrun_count (overrun_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply the rules for one rising edge, given the inputs held across it.
    task automatic model_edge(input logic rst, input logic raw, input logic fe, input logic cm);
        logic v;
        if (!rst) begin
            m_ready = 1'b0;
            for (int k = 0; k < 4; k++) m_disp[k] = '0;
            m_ovr = 0; m_db = 1'b0; m_run = 0; m_rose = 1'b0; m_pressed = 1'b0;
            samp = '{1'b0, 1'b0};
            return;
        end
        // Debounced level follows a value seen DEB times in a row, two edges late.
        v = samp[0];
        void'(samp.pop_front());
        samp.push_back(raw);
        m_pressed = m_rose;
        m_rose = 1'b0;
        if (v != m_db) begin
            m_run++;
            if (m_run == DEB) begin
                m_db = v; m_run = 0; m_rose = v;
            end
        end else begin
            m_run = 0;
        end
        // Handshake rules
        if (m_ready && cm) begin
            m_disp[0] = cpu_x; m_disp[1] = cpu_y; m_disp[2] = cpu_obs_x; m_disp[3] = cpu_obs_y;
            m_ready = fe;
        end else if (m_ready && fe) begin
            if (m_ovr < 65535) m_ovr++;
        end else if (!m_ready && fe) begin
            m_ready = 1'b1;
        end
    endtask

    task automatic compare_all();
        logic [31:0] rs, bs;
        rs = m_ready ? 32'h7 : 32'h0;
        bs = m_db ? 32'h7 : 32'h0;
        chk("screen_status", screen_status, rs);
        chk("button_status", button_status, bs);
        chk("button_pressed", {31'b0, button_pressed}, {31'b0, m_pressed});
        chk("disp_x", disp_x, m_disp[0]);
        chk("disp_y", disp_y, m_disp[1]);
        chk("disp_obs_x", disp_obs_x, m_disp[2]);
        chk("disp_obs_y", disp_obs_y, m_disp[3]);
        chk("overrun_count", {16'b0, overrun_count}, m_ovr[31:0]);
    endtask

    task automatic cycle(input logic rst, input logic btn, input logic fe, input logic cm);
        reset = rst; button_raw = btn; frame_end = fe; cpu_commit = cm;
        @(posedge clk);
        model_edge(rst, btn, fe, cm);
        @(negedge clk);
        compare_all();
        $display("t=%0t rst=%b btn=%b fe=%b cm=%b scr=%0h btn_st=%0h press=%b dx=%0d ovr=%0d",
                 $time, rst, btn, fe, cm, screen_status, button_status, button_pressed,
                 disp_x, overrun_count);
    endtask

    initial begin
        int presses;
        logic btn_lvl;
        cpu_x = 0; cpu_y = 0; cpu_obs_x = 0; cpu_obs_y = 0;
        samp = '{1'b0, 1'b0};

        // 1: reset then idle
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset_screen", screen_status, 32'h0);
        chk("reset_ovr", {16'b0, overrun_count}, 32'h0);

        // 2: single handshake
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        chk("ready_after_frame", screen_status, 32'h7);
        cpu_x = 100; cpu_y = 200; cpu_obs_x = 640; cpu_obs_y = 200;
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        chk("hs_disp_x", disp_x, 32'd100);
        chk("hs_disp_obs_x", disp_obs_x, 32'd640);
        chk("hs_screen", screen_status, 32'h0);

        // 3: overrun, then simultaneous commit and frame_end
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        chk("overrun_one", {16'b0, overrun_count}, 32'd1);
        chk("overrun_ready", screen_status, 32'h7);
        cpu_x = 7; cpu_y = 8; cpu_obs_x = 9; cpu_obs_y = 10;
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        chk("simul_screen", screen_status, 32'h7);
        chk("simul_ovr", {16'b0, overrun_count}, 32'd1);
        chk("simul_disp_y", disp_y, 32'd8);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);

        // 4: commit while waiting is ignored
        cpu_x = 5;
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        chk("wait_commit_disp_x", disp_x, 32'd7);
        chk("wait_commit_screen", screen_status, 32'h0);

        // 5: glitch, then a clean press
        repeat (3) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (10) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("glitch_status", button_status, 32'h0);
        presses = 0;
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0);
            if (button_pressed) presses++;
            if (i == 5) chk("db_before_6", button_status, 32'h0);
            if (i == 6) chk("db_at_6", button_status, 32'h7);
            if (i == 7) chk("pressed_at_7", {31'b0, button_pressed}, 32'd1);
            if (i == 8) chk("pressed_at_8", {31'b0, button_pressed}, 32'd0);
        end
        chk("press_count", presses, 32'd1);

        // 6: reset while READY with the button debounced high
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        chk("pre_reset_ready", screen_status, 32'h7);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        chk("midreset_screen", screen_status, 32'h0);
        chk("midreset_button", button_status, 32'h0);
        chk("midreset_disp_x", disp_x, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        chk("post_reset_wait", screen_status, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        chk("post_reset_ready", screen_status, 32'h7);

        // Randomized traffic against the model
        btn_lvl = 1'b1;
        for (int i = 0; i < 400; i++) begin
            cpu_x = $urandom; cpu_y = $urandom; cpu_obs_x = $urandom; cpu_obs_y = $urandom;
            if ($urandom_range(0, 7) == 0) btn_lvl = ~btn_lvl;
            cycle(($urandom_range(0, 99) != 0), btn_lvl,
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
